// File: rtl/stmtlocal_seq_pkg.sv
// Shared types and defaults for the lane sequencer and its increment-twice datapath.
package stmtlocal_seq_pkg;
  localparam int LANE_W_DEF = 32;
  localparam int NLANES_DEF = 4;

  typedef logic [LANE_W_DEF-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/stmtlocal_lane_inc2.sv
// Combinational lane datapath: res = (lane + 1) + 1 through a statement-local temporary.
// With STMTLOCAL_LANE_OVF_EN defined it also reports whether either increment wrapped.
module stmtlocal_lane_inc2
  import stmtlocal_seq_pkg::*;
(
  input  lane_t lane,
  output lane_t res
`ifdef STMTLOCAL_LANE_OVF_EN
  ,
  output logic  carry
`endif
);

  always_comb begin
    lane_t tmp;
`ifdef STMTLOCAL_LANE_OVF_EN
    logic  c1;
    logic  c2;
    // c1 fires for lane all-ones, c2 for lane all-ones minus one
    {c1, tmp} = {1'b0, lane} + {{LANE_W_DEF{1'b0}}, 1'b1};
    {c2, res} = {1'b0, tmp}  + {{LANE_W_DEF{1'b0}}, 1'b1};
    carry     = c1 | c2;
`else
    tmp = lane + lane_t'(1);
    res = tmp + lane_t'(1);
`endif
  end

endmodule

// File: rtl/stmtlocal_lane_sequencer.sv
// Serialises a word of NLANES lanes through one shared increment-twice datapath and reassembles it.
// Optional per-lane wrap flags on ovf when STMTLOCAL_LANE_OVF_EN is defined.
module stmtlocal_lane_sequencer
  import stmtlocal_seq_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int NLANES = NLANES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANE_W*NLANES-1:0] in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W*NLANES-1:0] out,
  output logic                     busy
`ifdef STMTLOCAL_LANE_OVF_EN
  ,
  output logic [NLANES-1:0]        ovf
`endif
);

  localparam int IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [LANE_W*NLANES-1:0]   word_q;
  lane_t                      lane_cur;
  lane_t                      lane_res;
`ifdef STMTLOCAL_LANE_OVF_EN
  logic                       lane_carry;
`endif

  assign lane_cur = word_q[idx*LANE_W +: LANE_W];

  stmtlocal_lane_inc2 u_inc2 (
    .lane  (lane_cur),
    .res   (lane_res)
`ifdef STMTLOCAL_LANE_OVF_EN
    ,
    .carry (lane_carry)
`endif
  );

  // in_ready/busy/out_valid are registered copies of the state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      word_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef STMTLOCAL_LANE_OVF_EN
      ovf       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word_q   <= in;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          out[idx*LANE_W +: LANE_W] <= lane_res;
`ifdef STMTLOCAL_LANE_OVF_EN
          ovf[idx]                  <= lane_carry;
`endif
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NLANES-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Input stays closed on the completing edge; the next word lands one cycle later.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stmtlocal_lane_sequencer.sv
// Scoreboard bench for stmtlocal_lane_sequencer; ovf checks appear with STMTLOCAL_LANE_OVF_EN.
module tb_stmtlocal_lane_sequencer;
  localparam int LW = 32;
  localparam int NL = 4;
  localparam int W  = LW*NL;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         busy;
`ifdef STMTLOCAL_LANE_OVF_EN
  logic [NL-1:0] ovf;
  logic [NL-1:0] ovf_q[$];
  logic [NL-1:0] exp_ovf;
`endif

  int           checks = 0;
  int           passes = 0;
  int           cyc    = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic         hs_in;

  stmtlocal_lane_sequencer #(.LANE_W(LW), .NLANES(NL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
`ifdef STMTLOCAL_LANE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = w[i*LW +: LW] + 32'd2;
    return r;
  endfunction

  function automatic logic [NL-1:0] ovf_model(input logic [W-1:0] w);
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = (w[i*LW +: LW] >= 32'hFFFF_FFFE);
    return r;
  endfunction

  // One clock: record the input handshake (scoreboard push) and land at edge+1.
  task automatic cycle();
    hs_in = in_valid && in_ready;
    if (hs_in) begin
      exp_q.push_back(model(in));
`ifdef STMTLOCAL_LANE_OVF_EN
      ovf_q.push_back(ovf_model(in));
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_out(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in = '0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags got=%b want=100", {in_ready, out_valid, busy});
    else passes++;
    checks++;
    if (out !== '0) $display("FAIL reset_out got=%h want=0", out);
    else passes++;
`ifdef STMTLOCAL_LANE_OVF_EN
    checks++;
    if (ovf !== '0) $display("FAIL reset_ovf got=%b want=0", ovf);
    else passes++;
`endif
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    int lat, busy_n;
    in = 128'h00000003_00000002_00000001_00000000; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; in = 'x;
    lat = 1; busy_n = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_n++;
      cycle(); lat++;
    end
    if (busy) busy_n++;
    checks++;
    if (lat !== 5) $display("FAIL basic_latency got=%0d want=5", lat);
    else passes++;
    exp_w = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++;
    if (out !== exp_w || exp_w !== 128'h00000005_00000004_00000003_00000002)
      $display("FAIL basic_out got=%h want=%h", out, 128'h00000005_00000004_00000003_00000002);
    else passes++;
`ifdef STMTLOCAL_LANE_OVF_EN
    exp_ovf = ovf_q.size() ? ovf_q.pop_front() : 'x;
    checks++;
    if (ovf !== exp_ovf) $display("FAIL basic_ovf got=%b want=%b", ovf, exp_ovf);
    else passes++;
`endif
    cycle();
    checks++;
    if (busy_n !== 5 || busy !== 1'b0) $display("FAIL basic_busy got=%0d cycles busy_now=%b want=5/0", busy_n, busy);
    else passes++;
  endtask

  task automatic test_wrap();
    bit ok;
    in = 128'hFFFFFFFF_FFFFFFFE_7FFFFFFF_FFFFFFFD; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    wait_out(20, ok);
    exp_w = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || out !== exp_w || exp_w !== 128'h00000001_00000000_80000001_FFFFFFFF)
      $display("FAIL wrap_out got=%h want=%h ok=%0d", out, 128'h00000001_00000000_80000001_FFFFFFFF, ok);
    else passes++;
`ifdef STMTLOCAL_LANE_OVF_EN
    exp_ovf = ovf_q.size() ? ovf_q.pop_front() : 'x;
    checks++;
    if (ovf !== exp_ovf || exp_ovf !== 4'b1100) $display("FAIL wrap_ovf got=%b want=1100", ovf);
    else passes++;
`endif
    cycle();
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    in = 128'h01234567_89ABCDEF_00000000_DEADBEEF; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in = 128'h11111111_22222222_33333333_44444444;
    wait_out(20, ok);
    checks++;
    if (!ok) $display("FAIL bp_timeout got=no out_valid want=out_valid");
    else passes++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out !== exp_q[0] || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      cycle();
    end
    checks++;
    if (bad !== 0) $display("FAIL bp_stable got=%0d bad cycles want=0", bad);
    else passes++;
    out_ready = 1'b1;
    exp_w = exp_q.pop_front();
    checks++;
    if (out !== exp_w) $display("FAIL bp_out got=%h want=%h", out, exp_w);
    else passes++;
`ifdef STMTLOCAL_LANE_OVF_EN
    void'(ovf_q.pop_front());
`endif
    cycle();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL bp_no_same_edge got=in_ready%b busy%b q%0d want=1/0/0", in_ready, busy, exp_q.size());
    else passes++;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (!hs_in || busy !== 1'b1) $display("FAIL bp_second_accept got=hs%0d busy%b want=1/1", hs_in, busy);
    else passes++;
    wait_out(20, ok);
    exp_w = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || out !== exp_w) $display("FAIL bp_second_out got=%h want=%h", out, exp_w);
    else passes++;
`ifdef STMTLOCAL_LANE_OVF_EN
    void'(ovf_q.pop_front());
`endif
    cycle();
  endtask

  task automatic test_back_to_back();
    int hs_t[$];
    int got;
    logic [W-1:0] first;
    in = {4{32'h10}}; in_valid = 1'b1; out_ready = 1'b1;
    got = 0; first = '0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      if (out_valid && out_ready) begin
        exp_w = exp_q.size() ? exp_q.pop_front() : 'x;
`ifdef STMTLOCAL_LANE_OVF_EN
        void'(ovf_q.pop_front());
`endif
        if (got == 0) first = out;
        checks++;
        if (out !== exp_w) $display("FAIL b2b_out%0d got=%h want=%h", got, out, exp_w);
        else passes++;
        got++;
      end
      cycle();
      if (hs_in) begin
        hs_t.push_back(cyc);
        if (hs_t.size() == 1) in = {4{32'h20}};
        else in_valid = 1'b0;
      end
    end
    checks++;
    if (got != 2 || first !== {4{32'h12}}) $display("FAIL b2b_first got=%h n=%0d want=%h", first, got, {4{32'h12}});
    else passes++;
    checks++;
    if (hs_t.size() != 2 || hs_t[1] - hs_t[0] != 6)
      $display("FAIL b2b_spacing got=%0d want=6", hs_t.size() == 2 ? hs_t[1] - hs_t[0] : -1);
    else passes++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    in = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out !== '0)
      $display("FAIL mid_reset got=v%b b%b r%b out=%h want=0/0/1 out=0", out_valid, busy, in_ready, out);
    else passes++;
    exp_q.delete();
`ifdef STMTLOCAL_LANE_OVF_EN
    ovf_q.delete();
`endif
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_release got=r%b b%b want=1/0", in_ready, busy);
    else passes++;
    in = 128'h00000000_FFFFFFFF_12345678_00000100; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    wait_out(20, ok);
    exp_w = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || out !== exp_w) $display("FAIL mid_next_out got=%h want=%h", out, exp_w);
    else passes++;
`ifdef STMTLOCAL_LANE_OVF_EN
    exp_ovf = ovf_q.size() ? ovf_q.pop_front() : 'x;
    checks++;
    if (ovf !== exp_ovf) $display("FAIL mid_next_ovf got=%b want=%b", ovf, exp_ovf);
    else passes++;
`endif
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
